fwd_select_ctrl: RTL and testbench

//  Drives the 2-bit select inputs of the EX-stage 4:1 operand muxes (A and B) of the pipelined CPU.

---
 rtl/fwd_select_ctrl.sv | 124 ++++++++++++
 tb/tb_fwd_select_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_ctrl.sv
// Forwarding-select and load-use hazard control for the EX-stage operand muxes.
// Tracks destination info for EX/MEM/WB and registers the 2-bit mux selects for the instruction entering EX.
module fwd_select_ctrl #(
    parameter int RA_W     = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_wr,
    input  logic            id_mem_rd,
    input  logic            flush,
    output logic            stall,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;
    localparam logic [1:0] SEL_PWB = 2'b11;

    logic            ex_v_q, mem_v_q, wb_v_q;
    logic            ex_v_d, mem_v_d, wb_v_d;
    logic [RA_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic [RA_W-1:0] ex_rd_d, mem_rd_d, wb_rd_d;
    logic            ex_wr_q, mem_wr_q, wb_wr_q;
    logic            ex_wr_d, mem_wr_d, wb_wr_d;
    logic            ex_ld_q, ex_ld_d;
    logic [1:0]      fwd_a_q, fwd_a_d;
    logic [1:0]      fwd_b_q, fwd_b_d;
    logic            load_use;

    function automatic logic src_is_zero(input logic [RA_W-1:0] src);
        return ZERO_REG && (src == '0);
    endfunction

    function automatic logic hits(input logic v, input logic wr,
                                  input logic [RA_W-1:0] rd,
                                  input logic [RA_W-1:0] src);
        return v && wr && (rd == src) && !src_is_zero(src);
    endfunction

    // Youngest producer wins: the EX entry holds the most recent write to src.
    function automatic logic [1:0] sel_for(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = SEL_RF;
        if (hits(ex_v_q, ex_wr_q, ex_rd_q, src)) begin
            sel = SEL_EXM;
        end else if (hits(mem_v_q, mem_wr_q, mem_rd_q, src)) begin
            sel = SEL_MWB;
        end else if (hits(wb_v_q, wb_wr_q, wb_rd_q, src)) begin
            sel = SEL_PWB;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_v_q && ex_ld_q) begin
            load_use = hits(ex_v_q, ex_wr_q, ex_rd_q, id_rs1) ||
                       hits(ex_v_q, ex_wr_q, ex_rd_q, id_rs2);
        end
    end

    assign stall = load_use;

    always_comb begin
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        mem_wr_d = ex_wr_q;
        wb_v_d   = mem_v_q;
        wb_rd_d  = mem_rd_q;
        wb_wr_d  = mem_wr_q;

        ex_v_d   = 1'b0;
        ex_rd_d  = id_rd;
        ex_wr_d  = id_reg_wr;
        ex_ld_d  = id_mem_rd;
        fwd_a_d  = SEL_RF;
        fwd_b_d  = SEL_RF;

        // A flushed or stalled ID instruction becomes a bubble; the EX instruction still moves on.
        if (!flush && !load_use && id_valid) begin
            ex_v_d  = 1'b1;
            fwd_a_d = sel_for(id_rs1);
            fwd_b_d = sel_for(id_rs2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q  <= 1'b0;
            mem_v_q <= 1'b0;
            wb_v_q  <= 1'b0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            ex_v_q  <= ex_v_d;
            mem_v_q <= mem_v_d;
            wb_v_q  <= wb_v_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Payload fields are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        ex_rd_q  <= ex_rd_d;
        ex_wr_q  <= ex_wr_d;
        ex_ld_q  <= ex_ld_d;
        mem_rd_q <= mem_rd_d;
        mem_wr_q <= mem_wr_d;
        wb_rd_q  <= wb_rd_d;
        wb_wr_q  <= wb_wr_d;
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed bench for fwd_select_ctrl: forwarding distance/priority, load-use stall, zero register, flush, reset.
module tb_fwd_select_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_wr, id_mem_rd, flush;
    logic       stall;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int n_checks = 0;
    int n_pass   = 0;

    fwd_select_ctrl #(.RA_W(5), .ZERO_REG(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_reg_wr (id_reg_wr),
        .id_mem_rd (id_mem_rd),
        .flush     (flush),
        .stall     (stall),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid  = v;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_reg_wr = wr;
        id_mem_rd = ld;
    endtask

    // Present an instruction in ID and advance one edge; afterwards it sits in EX.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic ld);
        set_id(v, rs1, rs2, rd, wr, ld);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            flush = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_a", fwd_a_sel, 2'b00);
        check_eq("rst_b", fwd_b_sel, 2'b00);
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        issue(1'b1, 5'd3, 5'd0, 5'd1, 1'b1, 1'b0);
        check_eq("lone_a", fwd_a_sel, 2'b00);
        check_eq("lone_b", fwd_b_sel, 2'b00);

        // EX forwarding
        drain();
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        issue(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        check_eq("exfwd_a", fwd_a_sel, 2'b01);
        check_eq("exfwd_b", fwd_b_sel, 2'b01);

        // Distance 1..4
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        check_eq("dist1_a", fwd_a_sel, 2'b01);
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        nop();
        issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        check_eq("dist2_a", fwd_a_sel, 2'b10);
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        nop();
        nop();
        issue(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        check_eq("dist3_b", fwd_b_sel, 2'b11);
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        nop();
        nop();
        nop();
        issue(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
        check_eq("dist4_a", fwd_a_sel, 2'b00);
        check_eq("dist4_b", fwd_b_sel, 2'b00);

        // Double writer: youngest wins
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
        check_eq("prio_a", fwd_a_sel, 2'b01);

        // Mixed distances on A and B; non-writer must not match
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        issue(1'b1, 5'd10, 5'd9, 5'd8, 1'b1, 1'b0);
        check_eq("mix_a", fwd_a_sel, 2'b01);
        check_eq("mix_b", fwd_b_sel, 2'b10);
        issue(1'b1, 5'd0, 5'd0, 5'd14, 1'b0, 1'b0);
        issue(1'b1, 5'd14, 5'd0, 5'd8, 1'b1, 1'b0);
        check_eq("nowr_a", fwd_a_sel, 2'b00);

        // Load-use
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        set_id(1'b1, 5'd1, 5'd4, 5'd11, 1'b1, 1'b0);
        #1;
        check_eq("lu_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        check_eq("lu_bub_a", fwd_a_sel, 2'b00);
        check_eq("lu_bub_b", fwd_b_sel, 2'b00);
        check_eq("lu_stall_off", stall, 1'b0);
        @(posedge clk);
        #1;
        check_eq("lu_fwd_b", fwd_b_sel, 2'b10);
        check_eq("lu_fwd_a", fwd_a_sel, 2'b00);
        check_eq("lu_nostall", stall, 1'b0);

        // Load with idle ID must not stall
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        set_id(1'b0, 5'd4, 5'd4, 5'd11, 1'b1, 1'b0);
        #1;
        check_eq("lu_idle", stall, 1'b0);

        // Zero register
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
        check_eq("zero_a", fwd_a_sel, 2'b00);
        check_eq("zero_b", fwd_b_sel, 2'b00);
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
        #1;
        check_eq("zero_stall", stall, 1'b0);

        // Flush together with stall
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        set_id(1'b1, 5'd0, 5'd4, 5'd13, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check_eq("fl_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("fl_a", fwd_a_sel, 2'b00);
        check_eq("fl_b", fwd_b_sel, 2'b00);
        issue(1'b1, 5'd13, 5'd4, 5'd8, 1'b1, 1'b0);
        check_eq("fl_killed_a", fwd_a_sel, 2'b00);
        check_eq("fl_load_b", fwd_b_sel, 2'b10);

        // Flush of a plain instruction: it must not be forwarded from later
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(1'b1, 5'd15, 5'd15, 5'd8, 1'b1, 1'b0);
        check_eq("fl2_a", fwd_a_sel, 2'b00);

        // Asynchronous reset mid-cycle
        drain();
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
        check_eq("ar_pre_a", fwd_a_sel, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_a", fwd_a_sel, 2'b00);
        check_eq("ar_b", fwd_b_sel, 2'b00);
        check_eq("ar_stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
        check_eq("ar_post_a", fwd_a_sel, 2'b00);
        check_eq("ar_post_b", fwd_b_sel, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
